conv2d_stream_kxk: RTL and testbench
====================================

// Module: conv2d_stream_kxk
// PURPOSE
//  Streaming single-channel KxK 2-D convolution (valid padding) for the CNN layer chain.
//  Accepts one raster-order pixel per in_valid and produces (IMG_W-K+1)x(IMG_H-K+1) outputs.
//  Successor to the fixed 9x9 conv stages: runtime-loadable kernel, parameterised geometry,
//  valid-gated input (stalls allowed), round-half-up, saturation and optional ReLU.
// PARAMETERS
//  DATA_W  16    signed pixel/coef/output width
//  FRAC    12    fractional bits of coefficients (Q(DATA_W-FRAC).FRAC)
//  K       9     kernel size (odd, 3..11)
//  IMG_W   96    input columns
//  IMG_H   96    input rows
//  ACC_W   40    accumulator width (>= 2*DATA_W + clog2(K*K))
//  BIAS    -1975 signed output-domain bias, DATA_W bits
//  RELU    0     1: clamp negative results to 0 after saturation
// PORTS
//  clk_in     in   1                 clock, all logic on rising edge
//  rst_n      in   1                 reset, synchronous, active-low
//  start      in   1                 pulse: begin frame (ignored while busy)
//  in_valid   in   1                 in_data valid this cycle
//  in_data    in   DATA_W            signed pixel, raster order
//  coef_we    in   1                 coefficient write strobe (ignored while busy)
//  coef_addr  in   clog2(K*K)        row*K+col; addr >= K*K ignored
//  coef_data  in   DATA_W            signed coefficient
//  out_valid  out  1                 out_data valid, one-cycle qualifier
//  out_data   out  DATA_W            signed result
//  busy       out  1                 frame in progress
//  done       out  1                 one-cycle pulse after last output of frame
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, busy=0, done=0; row/col counters, line buffer,
//    window and valid pipeline cleared; coefficient file cleared to 0. Reset mid-frame aborts
//    frame with no done pulse.
//  - States: IDLE -> (start) RUN -> (last pixel accepted) DRAIN -> (last out_valid) DONE -> IDLE.
//    busy=1 in RUN/DRAIN; done=1 exactly in the DONE cycle.
//  - RUN: each in_valid pixel shifts into K-1 line buffers (IMG_W deep) + KxK window; col/row
//    count with col wrap at IMG_W-1. Pixels with in_valid=0 do not advance anything except
//    the output pipeline. in_valid in IDLE/DRAIN/DONE is ignored.
//  - Window complete when col>=K-1 and row>=K-1; only then a token enters the pipeline.
//  - Pipeline fixed LAT=4 cycles from accepting the completing pixel to out_valid:
//    S1 K*K products, S2 row sums (K), S3 total, S4 round/bias/sat. Advances every cycle.
//  - Arithmetic: acc = sum(coef[r*K+c]*win[r][c]) at ACC_W signed;
//    y = (acc + 2^(FRAC-1)) >>> FRAC  (round half toward +inf); y = y + BIAS;
//    saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; if RELU and y<0 then y=0.
//  - Window row 0 = oldest line, col 0 = oldest pixel (correlation, no kernel flip).
//  - start and coef_we in same cycle from IDLE: coef write applied, frame starts.
//  - Outputs per frame exactly (IMG_W-K+1)*(IMG_H-K+1); line buffers not cleared between
//    frames (garbage excluded by counters).
// STRUCTURE
//  - conv_pkg: DATA_W/FRAC defaults, function round_shift(), function sat_dw(), state enum.
//  - Sub-module conv_line_buffer (K-1 rows x IMG_W, shift-enable, outputs K taps/column).
//  - Top: coef regfile, window regs, counters, FSM, 4-stage MAC pipeline.
// TESTING (K=3, IMG_W=IMG_H=5, FRAC=12, BIAS=0, RELU=0 unless stated)
//  - Identity (coef[4]=4096, rest 0), ramp 0..24 -> out 6,7,8,11,12,13,16,17,18; done 4 cyc after last.
//  - Rounding: coef[8]=2048, all pixels 3 -> 2 (x9); all pixels -3 -> -1 (x9).
//  - Saturation: all coefs 4096, pixels 32767 -> 32767; pixels -32768 -> -32768; RELU=1 -> 0.
//  - Bias: BIAS=-1975, all-zero image -> nine outputs of -1975.
//  - in_valid toggled randomly 50% -> same 9 values/order as continuous; coef_we while busy ignored.
//  - rst_n low mid-frame (after pixel 12) -> outputs cleared, no done; next frame correct.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_pkg : shared defaults, FSM states and arithmetic helpers
// Revision 1.0
// ------------------------------------------------------------------
package conv_pkg;

  localparam int c_DATA_W_DEF = 16;
  localparam int c_FRAC_DEF   = 12;
  localparam int c_WIDE_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  // Round half toward +inf, then drop the fractional bits.
  function automatic logic signed [c_WIDE_W-1:0] round_shift(
    input logic signed [c_WIDE_W-1:0] acc,
    input int                         frac
  );
    logic signed [c_WIDE_W-1:0] res;
    if (frac <= 0) begin
      res = acc;
    end else begin
      res = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    end
    return res;
  endfunction

  function automatic logic signed [c_WIDE_W-1:0] sat_dw(
    input logic signed [c_WIDE_W-1:0] v,
    input int                         dw
  );
    logic signed [c_WIDE_W-1:0] hi;
    logic signed [c_WIDE_W-1:0] lo;
    logic signed [c_WIDE_W-1:0] res;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      res = hi;
    end else if (v < lo) begin
      res = lo;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_line_buffer : K-1 chained row delays, K vertical taps per column
// Revision 1.0
// ------------------------------------------------------------------
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF,
  parameter int K      = 9,
  parameter int IMG_W  = 96
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     shift_en_i,
  input  logic signed [DATA_W-1:0] pix_i,
  output logic signed [DATA_W-1:0] taps_o [K]
);

  logic signed [DATA_W-1:0] w_tail [K-1];

  // Tap K-1 is the incoming pixel; tap 0 is the oldest row, same column.
  assign taps_o[K-1] = pix_i;

  generate
    for (genvar l = 0; l < K - 1; l++) begin : g_line
      logic signed [DATA_W-1:0] mem_q [IMG_W];
      logic signed [DATA_W-1:0] w_in;

      if (l == 0) begin : g_head
        assign w_in = pix_i;
      end else begin : g_chain
        assign w_in = w_tail[l-1];
      end

      always_ff @(posedge clk_in) begin
        if (!rst_n) begin
          for (int x = 0; x < IMG_W; x++) mem_q[x] <= '0;
        end else if (shift_en_i) begin
          mem_q[0] <= w_in;
          for (int x = 1; x < IMG_W; x++) mem_q[x] <= mem_q[x-1];
        end
      end

      assign w_tail[l]       = mem_q[IMG_W-1];
      assign taps_o[K-2-l]   = mem_q[IMG_W-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/conv2d_stream_kxk.sv
`default_nettype none
// ------------------------------------------------------------------
// conv2d_stream_kxk : streaming KxK valid-padding 2-D convolution
// Revision 1.0
// ------------------------------------------------------------------
module conv2d_stream_kxk
  import conv_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF,
  parameter int FRAC   = c_FRAC_DEF,
  parameter int K      = 9,
  parameter int IMG_W  = 96,
  parameter int IMG_H  = 96,
  parameter int ACC_W  = 40,
  parameter int BIAS   = -1975,
  parameter bit RELU   = 1'b0
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_we,
  input  logic [$clog2(K*K)-1:0]   coef_addr,
  input  logic signed [DATA_W-1:0] coef_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     done
);

  localparam int c_KK    = K * K;
  localparam int c_PW    = 2 * DATA_W;
  localparam int c_COL_W = $clog2(IMG_W);
  localparam int c_ROW_W = $clog2(IMG_H);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
  localparam logic [c_COL_W-1:0] c_COL_WIN  = c_COL_W'(K - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_WIN  = c_ROW_W'(K - 1);

  conv_state_e              state_q, state_d;
  logic [c_COL_W-1:0]       col_q, col_d;
  logic [c_ROW_W-1:0]       row_q, row_d;
  logic                     w_accept;
  logic                     w_complete;
  logic                     w_busy;
  logic                     w_pipe_idle;

  logic signed [DATA_W-1:0] coef_q [c_KK];
  logic signed [DATA_W-1:0] win_q  [K][K];
  logic signed [DATA_W-1:0] w_taps [K];

  logic                     tok_q, v1_q, v2_q, v3_q, out_valid_q;
  logic signed [c_PW-1:0]   prod_q [c_KK];
  logic signed [ACC_W-1:0]  rsum_q [K];
  logic signed [ACC_W-1:0]  total_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic signed [ACC_W-1:0]  w_rsum [K];
  logic signed [ACC_W-1:0]  w_total;
  logic signed [c_WIDE_W-1:0] w_wide;
  logic signed [DATA_W-1:0] w_y;

  assign w_busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign w_pipe_idle = !(tok_q || v1_q || v2_q || v3_q);
  assign w_complete  = w_accept && (col_q >= c_COL_WIN) && (row_q >= c_ROW_WIN);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    w_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          w_accept = 1'b1;
          if (col_q == c_COL_LAST) begin
            col_d = '0;
            if (row_q == c_ROW_LAST) begin
              row_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      // The last output leaves once nothing is left in flight behind it.
      ST_DRAIN: begin
        if (out_valid_q && w_pipe_idle) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      for (int i = 0; i < c_KK; i++) coef_q[i] <= '0;
    end else if (coef_we && !w_busy && (32'(coef_addr) < c_KK)) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  conv_line_buffer #(
    .DATA_W (DATA_W),
    .K      (K),
    .IMG_W  (IMG_W)
  ) u_line_buffer (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .shift_en_i (w_accept),
    .pix_i      (in_data),
    .taps_o     (w_taps)
  );

  // Column K-1 of the window is the newest column, row K-1 the newest line.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      end
    end else if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= w_taps[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < K; r++) begin
      w_rsum[r] = '0;
      for (int c = 0; c < K; c++) begin
        w_rsum[r] = w_rsum[r] + ACC_W'(prod_q[r*K+c]);
      end
    end
    w_total = '0;
    for (int r = 0; r < K; r++) w_total = w_total + rsum_q[r];
  end

  always_comb begin
    w_wide = round_shift(c_WIDE_W'(total_q), FRAC) + c_WIDE_W'(BIAS);
    w_y    = DATA_W'(sat_dw(w_wide, DATA_W));
    if (RELU && w_y[DATA_W-1]) w_y = '0;
  end

  // Data registers run freely; only the valid chain marks real results.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      tok_q       <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < c_KK; i++) prod_q[i] <= '0;
      for (int r = 0; r < K; r++) rsum_q[r] <= '0;
      total_q     <= '0;
      out_data_q  <= '0;
    end else begin
      tok_q       <= w_complete;
      v1_q        <= tok_q;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          prod_q[r*K+c] <= c_PW'(coef_q[r*K+c]) * c_PW'(win_q[r][c]);
        end
      end
      for (int r = 0; r < K; r++) rsum_q[r] <= w_rsum[r];
      total_q <= w_total;
      if (v3_q) out_data_q <= w_y;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = w_busy;
  assign done      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream_kxk.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_conv2d_stream_kxk : randomized bench, three DUT flavours vs model
// Revision 1.0
// ------------------------------------------------------------------
module tb_conv2d_stream_kxk;

  localparam int DW   = 16;
  localparam int FR   = 12;
  localparam int KS   = 3;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int NPIX = W * H;
  localparam int NOUT = (W - KS + 1) * (H - KS + 1);

  typedef struct packed {
    int e0;
    int e1;
    int e2;
    int acyc;
  } exp_t;

  logic                 clk_in   = 1'b0;
  logic                 rst_n    = 1'b0;
  logic                 start    = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_data  = '0;
  logic                 coef_we  = 1'b0;
  logic [3:0]           coef_addr = '0;
  logic signed [DW-1:0] coef_data = '0;
  logic [2:0]           ov;
  logic signed [DW-1:0] od [3];
  logic [2:0]           bz;
  logic [2:0]           dn;

  int   img  [NPIX];
  int   coef [KS*KS];
  int   bias_of [3] = '{0, -1975, 0};
  bit   relu_of [3] = '{1'b0, 1'b0, 1'b1};
  exp_t exp_q [$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_ov_cyc = -100;
  int   done_cnt = 0;
  int   frm_outs = 0;

  generate
    for (genvar i = 0; i < 3; i++) begin : g_dut
      conv2d_stream_kxk #(
        .DATA_W (DW),
        .FRAC   (FR),
        .K      (KS),
        .IMG_W  (W),
        .IMG_H  (H),
        .ACC_W  (40),
        .BIAS   (i == 1 ? -1975 : 0),
        .RELU   (i == 2)
      ) u_dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (ov[i]),
        .out_data  (od[i]),
        .busy      (bz[i]),
        .done      (dn[i])
      );
    end
  endgenerate

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  // Direct correlation of the window whose top-left is (oy, ox).
  function automatic int ref_out(input int oy, input int ox, input int b);
    longint acc = 0;
    longint y;
    for (int i = 0; i < KS; i++)
      for (int j = 0; j < KS; j++)
        acc += longint'(coef[i*KS+j]) * longint'(img[(oy+i)*W + ox + j]);
    y = (acc + (longint'(1) << (FR - 1))) >>> FR;
    y = y + bias_of[b];
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    if (relu_of[b] && y < 0) y = 0;
    return int'(y);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (ov != 3'b000) begin
        frm_outs++;
        check("ov_all", ov, 7);
        if (exp_q.size() == 0) begin
          check("unexpected_ov", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_d0", od[0], e.e0);
          check("out_d1", od[1], e.e1);
          check("out_d2", od[2], e.e2);
          check("latency", cyc - e.acyc, 4);
        end
        last_ov_cyc = cyc;
      end
      if (dn != 3'b000) begin
        done_cnt++;
        check("done_all", dn, 7);
        check("done_after_last_ov", cyc - last_ov_cyc, 1);
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load_coefs(input bit with_start);
    coef_we   = 1'b1;
    coef_addr = 4'(9 + $urandom_range(0, 6));
    coef_data = DW'($urandom);
    step();
    for (int a = 0; a < KS*KS; a++) begin
      coef_addr = 4'(a);
      coef_data = DW'(coef[a]);
      start     = with_start && (a == KS*KS - 1);
      step();
    end
    coef_we = 1'b0;
    start   = 1'b0;
  endtask

  task automatic run_frame(input bit need_start, input int vpct, input bit noise,
                           input int abort_at);
    int p = 0;
    int guard = 0;
    bit v;
    exp_t e;
    frm_outs = 0;
    if (need_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    check("busy_run", bz, 7);
    while (p < NPIX) begin
      v        = ($urandom_range(0, 99) < vpct);
      in_valid = v;
      in_data  = v ? DW'(img[p]) : DW'($urandom);
      if (noise) begin
        coef_we   = ($urandom_range(0, 3) == 0);
        coef_addr = 4'($urandom_range(0, KS*KS - 1));
        coef_data = DW'($urandom);
        start     = ($urandom_range(0, 7) == 0);
      end
      if (v && (p % W) >= KS - 1 && (p / W) >= KS - 1) begin
        e.e0   = ref_out(p / W - KS + 1, p % W - KS + 1, 0);
        e.e1   = ref_out(p / W - KS + 1, p % W - KS + 1, 1);
        e.e2   = ref_out(p / W - KS + 1, p % W - KS + 1, 2);
        e.acyc = cyc + 1;
        exp_q.push_back(e);
      end
      step();
      if (v) begin
        p++;
        if (p == abort_at) break;
      end
    end
    in_valid = 1'b0;
    coef_we  = 1'b0;
    start    = 1'b0;
    if (abort_at == 0) begin
      while (dn[0] !== 1'b1 && guard < 40) begin
        @(negedge clk_in);
        guard++;
      end
      check("done_seen", dn[0], 1);
      @(negedge clk_in);
      check("done_pulse", dn[0], 0);
      check("idle_busy", bz, 0);
      check("frame_outputs", frm_outs, NOUT);
      check("exp_drained", exp_q.size(), 0);
      step();
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_ov%0d", tag, i), ov[i], 0);
      check($sformatf("%s_od%0d", tag, i), od[i], 0);
    end
    check({tag, "_busy"}, bz, 0);
    check({tag, "_done"}, dn, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int saved_done;
    rst_n = 1'b0;
    repeat (3) step();
    check_reset_state("rst");
    rst_n = 1'b1;
    step();

    // identity kernel on a ramp, continuous then 50% valid with bus noise
    foreach (coef[a]) coef[a] = 0;
    coef[4] = 4096;
    foreach (img[p]) img[p] = p;
    load_coefs(1'b0);
    run_frame(1'b1, 100, 1'b0, 0);
    run_frame(1'b1, 50, 1'b1, 0);

    // rounding half toward +inf, start in the same cycle as the last write
    foreach (coef[a]) coef[a] = 0;
    coef[8] = 2048;
    foreach (img[p]) img[p] = 3;
    load_coefs(1'b1);
    run_frame(1'b0, 100, 1'b0, 0);
    foreach (img[p]) img[p] = -3;
    run_frame(1'b1, 100, 1'b0, 0);

    // saturation at both rails
    foreach (coef[a]) coef[a] = 4096;
    foreach (img[p]) img[p] = 32767;
    load_coefs(1'b0);
    run_frame(1'b1, 100, 1'b0, 0);
    foreach (img[p]) img[p] = -32768;
    run_frame(1'b1, 70, 1'b0, 0);

    // bias only visible on an all-zero image
    foreach (coef[a]) coef[a] = int'($urandom_range(0, 65535)) - 32768;
    foreach (img[p]) img[p] = 0;
    load_coefs(1'b0);
    run_frame(1'b1, 100, 1'b0, 0);

    // random kernel and image with stalls and ignored writes/starts
    foreach (coef[a]) coef[a] = int'($urandom_range(0, 8191)) - 4096;
    foreach (img[p]) img[p] = int'($urandom_range(0, 65535)) - 32768;
    load_coefs(1'b0);
    run_frame(1'b1, 60, 1'b1, 0);

    // abort after pixel 12 (first completing window)
    foreach (img[p]) img[p] = int'($urandom_range(0, 65535)) - 32768;
    saved_done = done_cnt;
    run_frame(1'b1, 100, 1'b0, 13);
    exp_q.delete();
    rst_n = 1'b0;
    step();
    step();
    check_reset_state("abort");
    rst_n = 1'b1;
    repeat (10) step();
    check("no_done_after_abort", done_cnt, saved_done);

    // reset also cleared the kernel: only bias remains
    foreach (coef[a]) coef[a] = 0;
    foreach (img[p]) img[p] = int'($urandom_range(0, 65535)) - 32768;
    run_frame(1'b1, 60, 1'b0, 0);

    foreach (coef[a]) coef[a] = int'($urandom_range(0, 65535)) - 32768;
    foreach (img[p]) img[p] = int'($urandom_range(0, 65535)) - 32768;
    load_coefs(1'b0);
    run_frame(1'b1, 80, 1'b1, 0);

    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
